// File: rtl/s_add_rr_arbiter.sv
// Round-robin arbiter that time-shares one signed adder among NREQ requesters.
// One transaction in flight: grant in IDLE, add in CALC, hold result in RESP.
module s_add_rr_arbiter #(
    parameter int  WIDTH = 6,
    parameter int  NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [WIDTH:0]   res_out,
    output logic [IDW-1:0]          res_id
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          id_q, id_d;
    logic [IDW-1:0]          res_id_q, res_id_d;
    logic signed [WIDTH-1:0] op_a_q, op_a_d;
    logic signed [WIDTH-1:0] op_b_q, op_b_d;
    logic signed [WIDTH:0]   res_q, res_d;

    logic                    found;
    logic [IDW-1:0]          gnt;
    logic signed [WIDTH-1:0] sel_a, sel_b;

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
                sel_a = req_a[idx*WIDTH +: WIDTH];
                sel_b = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        res_id_d  = res_id_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // Gated by rst_n so ready reads 0 while reset is held.
                    req_ready[gnt] = rst_n;
                    op_a_d         = sel_a;
                    op_b_d         = sel_b;
                    id_d           = gnt;
                    ptr_d          = IDW'((int'(gnt) + 1) % NREQ);
                    state_d        = CALC;
                end
            end
            CALC: begin
                res_d    = $signed({op_a_q[WIDTH-1], op_a_q})
                         + $signed({op_b_q[WIDTH-1], op_b_q});
                res_id_d = id_q;
                state_d  = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
        end
    end

    assign res_valid = (state_q == RESP);
    assign res_out   = res_q;
    assign res_id    = res_id_q;

endmodule
